spongent_absorb_padder: RTL and testbench
=========================================

// Module: spongent_absorb_padder
// PURPOSE
//   Front end of the Spongent hash core. Accepts DATA_WIDTH-bit message words and splits
//   them into R_WIDTH-bit rate blocks. Appends the Spongent pad block (single 1 bit, then
//   zeros to R_WIDTH) after the last data byte. Feeds the absorb/permutation stage one
//   block per handshake, so that stage never sees raw words or padding logic.
// PARAMETERS
//   DATA_WIDTH  64  input word width. Must be a multiple of R_WIDTH.
//   R_WIDTH     8   rate r in bits; width of an emitted block.
//   CNT_WIDTH   4   width of s_bytes and of the internal block counter. Must hold DATA_WIDTH/R_WIDTH.
// PORTS
//   clk       in   1           clock; all logic on the rising edge
//   rst       in   1           synchronous, active-high reset
//   s_data    in   DATA_WIDTH  message word; first block is s_data[DATA_WIDTH-1 -: R_WIDTH]
//   s_valid   in   1           s_data, s_last and s_bytes are valid
//   s_last    in   1           word is the final word of the message
//   s_bytes   in   CNT_WIDTH   valid blocks in the final word (0..DATA_WIDTH/R_WIDTH); ignored unless s_last
//   s_ready   out  1           block accepts a word
//   m_block   out  R_WIDTH     rate block to the absorb stage
//   m_valid   out  1           m_block is valid
//   m_last    out  1           m_block is the pad block (final block of the message)
//   m_ready   in   1           absorb stage takes m_block
//   busy      out  1           high in any state other than IDLE
// BEHAVIOUR
//   - Reset values: s_ready=0 during rst, then 1. m_valid=0, m_last=0, m_block=0, busy=0. FSM goes to IDLE.
//   - Input handshake: s_valid & s_ready. Output handshake: m_valid & m_ready.
//   - s_ready=1 only in IDLE. There is one bubble cycle per word; words never overlap.
//   - FSM states: IDLE, SHIFT, PAD.
//   - IDLE, on input handshake:
//       sreg <= s_data; last_f <= s_last; cnt <= s_last ? min(s_bytes, DATA_WIDTH/R_WIDTH) : DATA_WIDTH/R_WIDTH.
//       Next state is SHIFT if the new cnt != 0, else PAD.
//   - SHIFT: m_valid=1, m_last=0, m_block=sreg[DATA_WIDTH-1 -: R_WIDTH].
//       On output handshake: sreg <= sreg << R_WIDTH; cnt <= cnt-1.
//       If cnt==1 at the handshake: go to PAD when last_f, else IDLE.
//   - PAD: m_valid=1, m_last=1, m_block={1'b1, (R_WIDTH-1)'b0} (0x80 for r=8). Output handshake -> IDLE.
//   - Latency: first block is valid the cycle after the input handshake. Full rate is 1 block/cycle while m_ready=1.
//   - Backpressure: while m_valid & !m_ready, m_block and m_last hold stable. m_valid never drops without a handshake.
//   - Empty message (s_last=1, s_bytes=0): only the pad block is emitted.
//   - s_bytes greater than DATA_WIDTH/R_WIDTH: clamped to DATA_WIDTH/R_WIDTH.
//   - The pad block is always a full extra block, because messages are block-aligned.
//   - Reset mid-operation (SHIFT or PAD): the next cycle is IDLE, m_valid=0, pending blocks are dropped, no pad is emitted.
// CONFIGURATION
//   SPONGENT_MSG_LEN_EN defined:
//     Adds output msg_len[31:0]: count of data blocks handshaken in the current message (pad excluded).
//     Adds output msg_len_valid: set on the PAD handshake; cleared on the next input handshake.
//     On the first input handshake after msg_len_valid=1, or after reset, msg_len clears to 0.
//     Counter wraps modulo 2^32. Both outputs reset to 0.
//   SPONGENT_MSG_LEN_EN undefined: neither port exists and there is no counter logic.
//     All other behaviour is identical.
// TESTING
//   1 Reset: hold rst 2 cycles -> m_valid=0, busy=0. First cycle after rst release: s_ready=1.
//   2 One word 64'h0102030405060708, s_last=1, s_bytes=8, m_ready=1 ->
//       blocks 01,02,..,08 on consecutive cycles, then 80 with m_last=1; 9 handshakes; then s_ready=1.
//   3 Empty message, s_last=1, s_bytes=0 -> single block 80 with m_last=1; msg_len=0 when enabled.
//   4 Word 64'hAABBCCDDEEFF1122 (s_last=0) then 64'h3344550000000000 (s_last=1, s_bytes=3) ->
//       AA,BB,CC,DD,EE,FF,11,22,33,44,55,80 with m_last only on 80; msg_len=11, msg_len_valid=1.
//   5 Backpressure: m_ready toggles 1,0,0,1 during test 2 -> m_block holds 02 during the stalls;
//       output order is unchanged; no block lost or duplicated.
//   6 Assert rst for 1 cycle after the 3rd block of test 2 ->
//       next cycle m_valid=0, busy=0; no 80 block follows; a new word is accepted normally.

Source files
------------

// File: rtl/spongent_absorb_padder.sv
// rtl/spongent_absorb_padder.sv - splits message words into rate blocks and appends the Spongent pad block
// Optional message-length counter enabled by defining SPONGENT_MSG_LEN_EN.
module spongent_absorb_padder #(
  parameter int DATA_WIDTH = 64,
  parameter int R_WIDTH    = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic [CNT_WIDTH-1:0]  s_bytes,
  output logic                  s_ready,
  output logic [R_WIDTH-1:0]    m_block,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy
`ifdef SPONGENT_MSG_LEN_EN
  ,
  output logic [31:0]           msg_len,
  output logic                  msg_len_valid
`endif
);

  localparam int NBLK = DATA_WIDTH / R_WIDTH;
  localparam logic [CNT_WIDTH-1:0] NBLK_C = CNT_WIDTH'(NBLK);
  localparam logic [R_WIDTH-1:0] PAD_BLOCK = {1'b1, {(R_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  load_cnt;
  logic                  last_f;
  logic                  in_hs;
  logic                  out_hs;

  // Non-final words always carry a full set of blocks; oversized counts are clamped.
  assign load_cnt = (s_last && (s_bytes < NBLK_C)) ? s_bytes : NBLK_C;
  assign s_ready  = (state == IDLE) && !rst;
  assign in_hs    = s_valid && s_ready;
  assign out_hs   = m_valid && m_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_block   = '0;
    case (state)
      IDLE: begin
        if (in_hs) state_nxt = (load_cnt != '0) ? SHIFT : PAD;
      end
      SHIFT: begin
        m_valid = 1'b1;
        m_block = sreg[DATA_WIDTH-1 -: R_WIDTH];
        if (out_hs && (cnt == CNT_WIDTH'(1))) state_nxt = last_f ? PAD : IDLE;
      end
      PAD: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_block = PAD_BLOCK;
        if (out_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      last_f <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_hs) begin
        sreg   <= s_data;
        last_f <= s_last;
        cnt    <= load_cnt;
      end else if ((state == SHIFT) && out_hs) begin
        sreg <= sreg << R_WIDTH;
        cnt  <= cnt - CNT_WIDTH'(1);
      end
    end
  end

`ifdef SPONGENT_MSG_LEN_EN
  // Length of a finished message stays readable until the next message starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_len       <= '0;
      msg_len_valid <= 1'b0;
    end else if (in_hs) begin
      msg_len_valid <= 1'b0;
      if (msg_len_valid) msg_len <= '0;
    end else if (out_hs && (state == SHIFT)) begin
      msg_len <= msg_len + 32'd1;
    end else if (out_hs && (state == PAD)) begin
      msg_len_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spongent_absorb_padder.sv
// tb/tb_spongent_absorb_padder.sv - scoreboard bench for spongent_absorb_padder
// Exercises the msg_len outputs when SPONGENT_MSG_LEN_EN is defined.
module tb_spongent_absorb_padder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [3:0]  s_bytes;
  logic        s_ready;
  logic [7:0]  m_block;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;
`ifdef SPONGENT_MSG_LEN_EN
  logic [31:0] msg_len;
  logic        msg_len_valid;
`endif

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  spongent_absorb_padder #(.DATA_WIDTH(64), .R_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_bytes(s_bytes),
    .s_ready(s_ready),
    .m_block(m_block),
    .m_valid(m_valid),
    .m_last(m_last),
    .m_ready(m_ready),
    .busy(busy)
`ifdef SPONGENT_MSG_LEN_EN
    ,
    .msg_len(msg_len),
    .msg_len_valid(msg_len_valid)
`endif
  );

  task automatic push_word(input logic [63:0] d, input logic last, input logic [3:0] bytes);
    int nb;
    logic [63:0] w;
    w  = d;
    nb = last ? ((bytes > 4'd8) ? 8 : int'(bytes)) : 8;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back({1'b0, w[63:56]});
      w = w << 8;
    end
    if (last) exp_q.push_back(9'h180);
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] bytes);
    int budget;
    budget  = 0;
    s_data  = d;
    s_last  = last;
    s_bytes = bytes;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    tests++;
    if (budget >= 20) begin
      fails++;
      $display("FAIL send_accept: s_ready=%b required 1 within 20 cycles", s_ready);
    end
    push_word(d, last, bytes);
    @(negedge clk);
    s_valid = 1'b0;
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL first_latency: m_valid=%b required 1", m_valid);
    end
  endtask

  task automatic drain(input logic [31:0] rdy_pat, input int max_hs, output int hs, output int cycles);
    int   c;
    logic prev_stall;
    logic [7:0] prev_block;
    logic prev_last;
    logic [8:0] exp;
    c = 0;
    hs = 0;
    prev_stall = 1'b0;
    prev_block = '0;
    prev_last  = 1'b0;
    while (exp_q.size() > 0 && hs < max_hs && c < 100) begin
      m_ready = (c < 32) ? rdy_pat[c] : 1'b1;
      if (prev_stall) begin
        tests++;
        if (m_valid !== 1'b1 || m_block !== prev_block || m_last !== prev_last) begin
          fails++;
          $display("FAIL hold: valid=%b block=%h last=%b required 1 %h %b",
                   m_valid, m_block, m_last, prev_block, prev_last);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        exp = exp_q.pop_front();
        tests++;
        if ({m_last, m_block} !== exp) begin
          fails++;
          $display("FAIL block[%0d]: last=%b block=%h required last=%b block=%h",
                   hs, m_last, m_block, exp[8], exp[7:0]);
        end
        hs++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = (m_valid === 1'b1);
        prev_block = m_block;
        prev_last  = m_last;
      end
      @(negedge clk);
      c++;
    end
    m_ready = 1'b1;
    cycles  = c;
    tests++;
    if (exp_q.size() != 0 && hs < max_hs) begin
      fails++;
      $display("FAIL drain_timeout: %0d blocks outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s: s_ready=%b busy=%b m_valid=%b required 1 0 0", name, s_ready, busy, m_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || m_block !== 8'h00 || m_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b busy=%b s_ready=%b block=%h last=%b required 0 0 0 00 0",
               m_valid, busy, s_ready, m_block, m_last);
    end
`ifdef SPONGENT_MSG_LEN_EN
    tests++;
    if (msg_len !== 32'd0 || msg_len_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_msg_len: len=%0d valid=%b required 0 0", msg_len, msg_len_valid);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_full_word();
    int hs, cyc;
    send_word(64'h0102030405060708, 1'b1, 4'd8);
    drain(32'hFFFF_FFFF, 100, hs, cyc);
    tests++;
    if (hs != 9 || cyc != 9) begin
      fails++;
      $display("FAIL full_rate: handshakes=%0d cycles=%0d required 9 9", hs, cyc);
    end
    check_idle("full_word_done");
  endtask

  task automatic test_empty();
    int hs, cyc;
    send_word(64'hDEAD_BEEF_0000_1111, 1'b1, 4'd0);
    drain(32'hFFFF_FFFF, 100, hs, cyc);
    tests++;
    if (hs != 1) begin
      fails++;
      $display("FAIL empty_count: handshakes=%0d required 1", hs);
    end
`ifdef SPONGENT_MSG_LEN_EN
    tests++;
    if (msg_len !== 32'd0 || msg_len_valid !== 1'b1) begin
      fails++;
      $display("FAIL empty_msg_len: len=%0d valid=%b required 0 1", msg_len, msg_len_valid);
    end
`endif
    check_idle("empty_done");
  endtask

  task automatic test_two_words();
    int hs, cyc;
    send_word(64'hAABBCCDDEEFF1122, 1'b0, 4'd0);
`ifdef SPONGENT_MSG_LEN_EN
    tests++;
    if (msg_len_valid !== 1'b0) begin
      fails++;
      $display("FAIL msg_len_valid_clear: valid=%b required 0", msg_len_valid);
    end
`endif
    drain(32'hFFFF_FFFF, 100, hs, cyc);
    tests++;
    if (hs != 8) begin
      fails++;
      $display("FAIL word1_count: handshakes=%0d required 8", hs);
    end
    send_word(64'h3344550000000000, 1'b1, 4'd3);
    drain(32'hFFFF_FFFF, 100, hs, cyc);
    tests++;
    if (hs != 4) begin
      fails++;
      $display("FAIL word2_count: handshakes=%0d required 4", hs);
    end
`ifdef SPONGENT_MSG_LEN_EN
    tests++;
    if (msg_len !== 32'd11 || msg_len_valid !== 1'b1) begin
      fails++;
      $display("FAIL two_word_msg_len: len=%0d valid=%b required 11 1", msg_len, msg_len_valid);
    end
`endif
  endtask

  task automatic test_clamp();
    int hs, cyc;
    send_word(64'h1020304050607080, 1'b1, 4'd15);
    drain(32'hFFFF_FFFF, 100, hs, cyc);
    tests++;
    if (hs != 9) begin
      fails++;
      $display("FAIL clamp_count: handshakes=%0d required 9", hs);
    end
  endtask

  task automatic test_backpressure();
    int hs, cyc;
    send_word(64'h0102030405060708, 1'b1, 4'd8);
    drain(32'hFFFF_FFF9, 100, hs, cyc);
    tests++;
    if (hs != 9 || cyc != 11) begin
      fails++;
      $display("FAIL backpressure_count: handshakes=%0d cycles=%0d required 9 11", hs, cyc);
    end
    check_idle("backpressure_done");
  endtask

  task automatic test_mid_reset();
    int hs, cyc;
    send_word(64'h0102030405060708, 1'b1, 4'd8);
    drain(32'hFFFF_FFFF, 3, hs, cyc);
    rst = 1'b1;
    tests++;
    if (s_ready !== 1'b0 || m_block !== 8'h04) begin
      fails++;
      $display("FAIL mid_reset_pre: s_ready=%b block=%h required 0 04", s_ready, m_block);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_post: m_valid=%b busy=%b required 0 0", m_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (m_valid !== 1'b0) begin
        fails++;
        $display("FAIL no_pad_after_reset: m_valid=%b block=%h required 0", m_valid, m_block);
      end
    end
    send_word(64'hCAFE_F00D_1234_5678, 1'b1, 4'd2);
    drain(32'hFFFF_FFFF, 100, hs, cyc);
    tests++;
    if (hs != 3) begin
      fails++;
      $display("FAIL after_reset_count: handshakes=%0d required 3", hs);
    end
    check_idle("after_reset_done");
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_bytes = '0;
    m_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_word();
    test_empty();
    test_two_words();
    test_clamp();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
